// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - load/store data-memory responder with RV32 sub-word access and wait states
module dmem_responder #(
  parameter int          DEPTH_WORDS = 256,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int          WAIT_CYCLES = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int AW = $clog2(DEPTH_WORDS);
  localparam logic [3:0] WAIT_LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t state, state_next;
  logic [31:0] mem [DEPTH_WORDS];
  logic [3:0]  cnt;

  logic          cap_we, cap_unsigned, cap_err;
  logic [1:0]    cap_size, cap_lane;
  logic [AW-1:0] cap_idx;

  logic [31:0]   off;
  logic          range_err, align_err, req_err, accept;
  logic [AW-1:0] req_idx;
  logic [1:0]    req_lane;
  logic [3:0]    wr_be;
  logic [31:0]   wr_data;

  // The subtraction is only meaningful when addr >= BASE_ADDR; the compare guards wrap.
  assign off       = req_addr - BASE_ADDR;
  assign req_idx   = off[AW+1:2];
  assign req_lane  = off[1:0];
  assign range_err = (req_addr < BASE_ADDR) || (off[31:AW+2] != '0);
  assign req_err   = range_err || align_err;
  assign accept    = req_valid && req_ready;

  always_comb begin
    align_err = 1'b0;
    wr_be     = 4'b1111;
    wr_data   = req_wdata;
    case (req_size)
      2'b00: begin
        wr_be   = 4'b0001 << req_lane;
        wr_data = {4{req_wdata[7:0]}};
      end
      2'b01: begin
        align_err = req_lane[0];
        wr_be     = req_lane[1] ? 4'b1100 : 4'b0011;
        wr_data   = {2{req_wdata[15:0]}};
      end
      2'b10:   align_err = (req_lane != 2'b00);
      default: align_err = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (accept && req_we && !req_err) begin
      for (int i = 0; i < 4; i++) begin
        if (wr_be[i]) mem[req_idx][8*i +: 8] <= wr_data[8*i +: 8];
      end
    end
  end

  function automatic logic [31:0] load_extend(input logic [31:0] word, input logic [1:0] size,
                                              input logic uns, input logic [1:0] lane);
    logic [31:0] sh;
    sh = word >> {lane, 3'b000};
    case (size)
      2'b00:   return uns ? {24'b0, sh[7:0]}  : {{24{sh[7]}}, sh[7:0]};
      2'b01:   return uns ? {16'b0, sh[15:0]} : {{16{sh[15]}}, sh[15:0]};
      default: return word;
    endcase
  endfunction

  // With zero wait states RESP is entered on the acceptance edge, so read from the live request.
  logic          sel_live, sel_we, sel_err;
  logic [AW-1:0] sel_idx;
  logic [31:0]   ld_data;

  assign sel_live = (state == S_IDLE);
  assign sel_we   = sel_live ? req_we  : cap_we;
  assign sel_err  = sel_live ? req_err : cap_err;
  assign sel_idx  = sel_live ? req_idx : cap_idx;
  assign ld_data  = sel_live ? load_extend(mem[sel_idx], req_size, req_unsigned, req_lane)
                             : load_extend(mem[sel_idx], cap_size, cap_unsigned, cap_lane);

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: if (accept) state_next = (WAIT_CYCLES > 0) ? S_WAIT : S_RESP;
      S_WAIT: if (cnt == 4'd0) state_next = S_RESP;
      S_RESP: if (rsp_ready) state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= S_IDLE;
      req_ready    <= 1'b0;
      rsp_valid    <= 1'b0;
      rsp_rdata    <= 32'd0;
      rsp_err      <= 1'b0;
      cnt          <= 4'd0;
      cap_we       <= 1'b0;
      cap_unsigned <= 1'b0;
      cap_err      <= 1'b0;
      cap_size     <= 2'b00;
      cap_lane     <= 2'b00;
      cap_idx      <= '0;
    end else begin
      state     <= state_next;
      req_ready <= (state_next == S_IDLE);
      rsp_valid <= (state_next == S_RESP);
      if (accept) begin
        cap_we       <= req_we;
        cap_unsigned <= req_unsigned;
        cap_err      <= req_err;
        cap_size     <= req_size;
        cap_lane     <= req_lane;
        cap_idx      <= req_idx;
        cnt          <= WAIT_LOAD;
      end else if (state == S_WAIT && cnt != 4'd0) begin
        cnt <= cnt - 4'd1;
      end
      if (state != S_RESP && state_next == S_RESP) begin
        rsp_err   <= sel_err;
        rsp_rdata <= (sel_err || sel_we) ? 32'd0 : ld_data;
      end else if (state == S_RESP && rsp_ready) begin
        rsp_err   <= 1'b0;
        rsp_rdata <= 32'd0;
      end
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// tb/tb_dmem_responder.sv - directed self-checking bench for dmem_responder (1 and 3 wait states)
module tb_dmem_responder;

  logic        clk = 1'b0;
  logic        reset;
  logic        sel;
  logic        req_valid, req_we, req_unsigned, rsp_ready;
  logic [31:0] req_addr, req_wdata;
  logic [1:0]  req_size;

  logic        req_ready1, rsp_valid1, rsp_err1;
  logic [31:0] rsp_rdata1;
  logic        req_ready3, rsp_valid3, rsp_err3;
  logic [31:0] rsp_rdata3;

  logic        req_ready, rsp_valid, rsp_err;
  logic [31:0] rsp_rdata;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  assign req_ready = sel ? req_ready3 : req_ready1;
  assign rsp_valid = sel ? rsp_valid3 : rsp_valid1;
  assign rsp_err   = sel ? rsp_err3   : rsp_err1;
  assign rsp_rdata = sel ? rsp_rdata3 : rsp_rdata1;

  dmem_responder #(.DEPTH_WORDS(256), .BASE_ADDR(32'h0), .WAIT_CYCLES(1)) u_dut1 (
    .clk(clk), .reset(reset), .req_valid(req_valid && !sel), .req_ready(req_ready1),
    .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata), .req_size(req_size),
    .req_unsigned(req_unsigned), .rsp_valid(rsp_valid1), .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata1), .rsp_err(rsp_err1)
  );

  dmem_responder #(.DEPTH_WORDS(256), .BASE_ADDR(32'h0), .WAIT_CYCLES(3)) u_dut3 (
    .clk(clk), .reset(reset), .req_valid(req_valid && sel), .req_ready(req_ready3),
    .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata), .req_size(req_size),
    .req_unsigned(req_unsigned), .rsp_valid(rsp_valid3), .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata3), .rsp_err(rsp_err3)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic do_req(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [1:0] size, input logic uns,
                        output logic [31:0] rdata, output logic err, output int lat);
    int n;
    n = 0;
    @(negedge clk);
    while (!req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) check("req_ready_timeout", 32'd0, 32'd1);
    req_we = we; req_addr = addr; req_wdata = wdata; req_size = size; req_unsigned = uns;
    req_valid = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    lat = 0;
    @(negedge clk);
    while (!rsp_valid && lat < 40) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    if (!rsp_valid) check("rsp_valid_timeout", 32'd0, 32'd1);
    rdata = rsp_rdata;
    err   = rsp_err;
    @(posedge clk);
    #1 check("rsp_valid_drop", {31'd0, rsp_valid}, 32'd0);
  endtask

  task automatic access(input string tag, input logic we, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [1:0] size, input logic uns,
                        input logic [31:0] exp_data, input logic exp_err);
    logic [31:0] d;
    logic        e;
    int          lat;
    do_req(we, addr, wdata, size, uns, d, e, lat);
    check({tag, "_data"}, d, exp_data);
    check({tag, "_err"}, {31'd0, e}, {31'd0, exp_err});
    check({tag, "_lat"}, lat, sel ? 32'd3 : 32'd1);
  endtask

  initial begin
    reset = 1'b0; sel = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_unsigned = 1'b0;
    rsp_ready = 1'b1; req_addr = '0; req_wdata = '0; req_size = 2'b10;
    repeat (3) @(posedge clk);
    #1;
    check("rst_req_ready", {31'd0, req_ready}, 32'd0);
    check("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("rst_rsp_rdata", rsp_rdata, 32'd0);
    check("rst_rsp_err", {31'd0, rsp_err}, 32'd0);
    @(negedge clk) reset = 1'b1;
    @(posedge clk);
    #1 check("rel_req_ready", {31'd0, req_ready}, 32'd1);

    // word store / load
    access("sw_10", 1'b1, 32'h10, 32'hDEADBEEF, 2'b10, 1'b0, 32'h0, 1'b0);
    access("lw_10", 1'b0, 32'h10, 32'h0, 2'b10, 1'b0, 32'hDEADBEEF, 1'b0);

    // sub-word extension
    access("sw_08", 1'b1, 32'h08, 32'h80FF7F01, 2'b10, 1'b0, 32'h0, 1'b0);
    access("lb_09", 1'b0, 32'h09, 32'h0, 2'b00, 1'b0, 32'h0000007F, 1'b0);
    access("lb_0a", 1'b0, 32'h0A, 32'h0, 2'b00, 1'b0, 32'hFFFFFFFF, 1'b0);
    access("lbu_0b", 1'b0, 32'h0B, 32'h0, 2'b00, 1'b1, 32'h00000080, 1'b0);
    access("lh_0a", 1'b0, 32'h0A, 32'h0, 2'b01, 1'b0, 32'hFFFF80FF, 1'b0);
    access("lhu_08", 1'b0, 32'h08, 32'h0, 2'b01, 1'b1, 32'h00007F01, 1'b0);

    // partial stores
    access("sw_20", 1'b1, 32'h20, 32'h11223344, 2'b10, 1'b0, 32'h0, 1'b0);
    access("sb_21", 1'b1, 32'h21, 32'hFFFFFFAB, 2'b00, 1'b0, 32'h0, 1'b0);
    access("lw_20a", 1'b0, 32'h20, 32'h0, 2'b10, 1'b0, 32'h1122AB44, 1'b0);
    access("sh_22", 1'b1, 32'h22, 32'h0000BEEF, 2'b01, 1'b0, 32'h0, 1'b0);
    access("lw_20b", 1'b0, 32'h20, 32'h0, 2'b10, 1'b0, 32'hBEEFAB44, 1'b0);

    // errors
    access("lw_13", 1'b0, 32'h13, 32'h0, 2'b10, 1'b0, 32'h0, 1'b1);
    access("sh_21", 1'b1, 32'h21, 32'h00001234, 2'b01, 1'b0, 32'h0, 1'b1);
    access("lw_20c", 1'b0, 32'h20, 32'h0, 2'b10, 1'b0, 32'hBEEFAB44, 1'b0);
    access("lw_oor", 1'b0, 32'h400, 32'h0, 2'b10, 1'b0, 32'h0, 1'b1);
    access("lw_last", 1'b0, 32'h3FC, 32'h0, 2'b10, 1'b0, 32'h0, 1'b0);
    access("size11", 1'b0, 32'h10, 32'h0, 2'b11, 1'b0, 32'h0, 1'b1);

    // backpressure with an intruding store that must be ignored
    begin
      int n;
      rsp_ready = 1'b0;
      @(negedge clk);
      req_we = 1'b0; req_addr = 32'h10; req_size = 2'b10; req_unsigned = 1'b0;
      req_valid = 1'b1;
      @(posedge clk);
      #1 req_valid = 1'b0;
      n = 0;
      @(negedge clk);
      while (!rsp_valid && n < 20) begin
        @(negedge clk);
        n++;
      end
      check("bp_rsp_seen", {31'd0, rsp_valid}, 32'd1);
      req_we = 1'b1; req_wdata = 32'h0BADF00D; req_valid = 1'b1;
      for (int i = 0; i < 5; i++) begin
        @(negedge clk);
        check("bp_valid", {31'd0, rsp_valid}, 32'd1);
        check("bp_data", rsp_rdata, 32'hDEADBEEF);
        check("bp_req_ready", {31'd0, req_ready}, 32'd0);
      end
      req_valid = 1'b0;
      rsp_ready = 1'b1;
      @(posedge clk);
      #1;
      check("bp_valid_drop", {31'd0, rsp_valid}, 32'd0);
      check("bp_ready_back", {31'd0, req_ready}, 32'd1);
      access("bp_lw_10", 1'b0, 32'h10, 32'h0, 2'b10, 1'b0, 32'hDEADBEEF, 1'b0);
    end

    // reset during WAIT on the three-wait-state responder
    sel = 1'b1;
    access("w3_sw_40", 1'b1, 32'h40, 32'h000055AA, 2'b10, 1'b0, 32'h0, 1'b0);
    @(negedge clk);
    req_we = 1'b0; req_addr = 32'h40; req_size = 2'b10; req_valid = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("mid_rst_valid", {31'd0, rsp_valid}, 32'd0);
    check("mid_rst_ready", {31'd0, req_ready}, 32'd0);
    check("mid_rst_data", rsp_rdata, 32'd0);
    check("mid_rst_err", {31'd0, rsp_err}, 32'd0);
    @(negedge clk) reset = 1'b1;
    @(posedge clk);
    #1 check("mid_rel_ready", {31'd0, req_ready}, 32'd1);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("no_stray_rsp", {31'd0, rsp_valid}, 32'd0);
    end
    access("w3_lw_40", 1'b0, 32'h40, 32'h0, 2'b10, 1'b0, 32'h000055AA, 1'b0);
    sel = 1'b0;
    access("post_rst_lw_10", 1'b0, 32'h10, 32'h0, 2'b10, 1'b0, 32'hDEADBEEF, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Responder side of the core's load/store data-memory interface; serves one request at a time from the datapath's load/store path.
- Owns a word-organised RAM and performs byte/half/word accesses with RV32 load sign/zero extension.
- Raises an error response for misaligned or out-of-range accesses.
- Uses a valid/ready request channel and a valid/ready response channel, with a configurable number of wait states.

Parameters:
- DEPTH_WORDS, 256, number of 32-bit words in the RAM; power of two, ≥4.
- BASE_ADDR, 32'h0000_0000, byte address of word 0; must be 4-byte aligned.
- WAIT_CYCLES, 1, extra cycles between request acceptance and response; 0..15.

Ports:
- clk  input  1  clock; all state changes on rising edge.
- reset  input  1  asynchronous, active-low reset.
- req_valid  input  1  request present.
- req_ready  output  1  responder can accept a request.
- req_we  input  1  1 = store, 0 = load.
- req_addr  input  32  byte address.
- req_wdata  input  32  store data; right-aligned (byte in [7:0], half in [15:0]).
- req_size  input  2  00 byte, 01 half, 10 word, 11 illegal (funct3[1:0]).
- req_unsigned  input  1  load zero-extends when 1 (funct3[2]); ignored for stores.
- rsp_valid  output  1  response present.
- rsp_ready  input  1  requester takes the response.
- rsp_rdata  output  32  load result, extended to 32 bits; 0 for stores and errors.
- rsp_err  output  1  access faulted.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE, req_ready=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, wait counter=0.
  - RAM contents are not cleared and persist across reset.
- req_ready is registered: it goes to 1 on the first clk edge after reset deasserts, and is 1 only in IDLE.
- States:
  - IDLE: request accepted on an edge with req_valid & req_ready. Go to WAIT if WAIT_CYCLES>0, else RESP. req_ready drops to 0 on that edge.
  - WAIT: counter loads WAIT_CYCLES-1 on acceptance and decrements each edge; go to RESP on the edge where counter=0.
  - RESP: rsp_valid=1. rsp_rdata and rsp_err stay stable until an edge with rsp_ready=1. On that edge: rsp_valid→0, rsp_rdata/rsp_err→0, state→IDLE, req_ready→1.
- Only one request outstanding; req_* inputs are ignored outside IDLE.
- Latency: with rsp_ready held high, rsp_valid is high in cycle T+1+WAIT_CYCLES, where T is the acceptance cycle. Back-to-back throughput is one request per 2+WAIT_CYCLES cycles.
- Error check, done at acceptance; rsp_err=1 for:
  - req_size=11;
  - half with addr[0]=1;
  - word with addr[1:0]≠0;
  - addr<BASE_ADDR;
  - (addr-BASE_ADDR)>>2 ≥ DEPTH_WORDS.
- On error: no RAM write, rsp_rdata=0.
- Word index = (addr-BASE_ADDR)>>2; byte lane = addr[1:0].
- Stores: committed to the RAM on the acceptance edge, writing only the addressed lanes.
  - Byte writes lane addr[1:0] with wdata[7:0].
  - Half writes lanes addr[1]*2 and +1 with wdata[15:0].
  - Word writes all four lanes.
  - Store response: rsp_rdata=0, rsp_err=0.
- Loads:
  - The RAM word is read on the edge entering RESP; the addressed lane(s) are shifted to bit 0.
  - Extension: sign-extend from bit 7/15 when req_unsigned=0, zero-extend when 1. Word loads pass through unchanged.
  - The size/unsigned/lane fields used for extension are those captured at acceptance.
- Simultaneous events:
  - The rsp_ready edge in RESP and a new req_valid do not overlap; the new request is accepted no earlier than the following edge, when req_ready=1.
  - rsp_ready asserted outside RESP is ignored.
- Reset mid-operation (WAIT or RESP): the response is discarded and no response is produced afterwards. A store already committed at acceptance remains in the RAM.
- Address arithmetic is 32-bit unsigned; the BASE_ADDR subtraction does not wrap (addr<BASE_ADDR is an error).

Test Plan:
1. Word store then load, WAIT_CYCLES=1:
   - Store 0xDEADBEEF to 0x10, rsp_ready=1 → store response 2 cycles after acceptance, rsp_err=0, rsp_rdata=0.
   - Load word 0x10 → rsp_rdata=0xDEADBEEF.
2. Sub-word extension, word 0x8 holding 0x80FF7F01:
   - lb 0x9 → 0x0000007F.
   - lb 0xA → 0xFFFFFFFF.
   - lbu 0xB → 0x00000080.
   - lh 0xA → 0xFFFF80FF.
   - lhu 0x8 → 0x00007F01.
3. Partial store: word 0x20 = 0x11223344, sb 0xAB to 0x21 → load word 0x20 returns 0x1122AB44. Then sh 0xBEEF to 0x22 → 0xBEEFAB44.
4. Errors:
   - lw 0x13 → rsp_err=1, rsp_rdata=0.
   - sh 0x21 → rsp_err=1 and word 0x20 unchanged.
   - lw 4*DEPTH_WORDS → rsp_err=1.
   - req_size=11 → rsp_err=1.
5. Backpressure: hold rsp_ready=0 for 5 cycles → rsp_valid stays 1 with stable data, req_ready stays 0, a new req_valid is ignored. Raise rsp_ready → rsp_valid drops next edge and req_ready=1.
6. Reset in WAIT (WAIT_CYCLES=3): assert reset mid-load → outputs 0 immediately. After release, req_ready=1 one edge later, no stray rsp_valid, and earlier RAM contents are still readable.
